muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised iterative multiply/divide unit for the RISC-V M extension. It sits in the execute stage beside the ALU and receives post-forwarding operands together with the pipelined `funct3`. While an operation is in flight it stalls the pipeline through the hazard unit. It produces a registered result that the EX/MEM register captures on the cycle `done_o` is high.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; legal values 32 or 64.
- `BITS_PER_CYCLE`, 1: quotient/multiplier bits retired per iteration; legal values 1, 2 or 4; must divide `XLEN`.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `start_i`  in  1  the EX-stage instruction is an M-extension op; sampled only in IDLE.
- `funct3_i`  in  3  operation select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
- `operand_a_i`  in  XLEN  rs1 value, after forwarding.
- `operand_b_i`  in  XLEN  rs2 value, after forwarding.
- `flush_i`  in  1  kill any in-flight operation (branch redirect or trap).
- `busy_o`  out  1  stall request to the hazard unit.
- `done_o`  out  1  one-cycle pulse; `result_o` is valid.
- `result_o`  out  XLEN  registered result; holds its value until the next completion.

## Operation
- States: IDLE, CALC, DONE. N = XLEN/BITS_PER_CYCLE.
- IDLE, `start_i`=1, `flush_i`=0:
  - Latch `funct3_i`.
  - Take magnitudes of the signed operands: a for MULH/MULHSU/DIV/REM; b for MULH/DIV/REM.
  - Record the result negate flag: sign(a) XOR sign(b) for products and quotients; sign(a) for remainders.
  - Special case, divide by zero (b=0): go directly to DONE. Quotient = all ones; remainder = a.
  - Special case, signed overflow (a = most-negative value, b = -1, DIV/REM only): go directly to DONE. Quotient = a; remainder = 0.
  - Otherwise load the iteration counter with N and go to CALC.
- CALC: each cycle performs one `BITS_PER_CYCLE` step.
  - Multiply: shift-add into a 2·XLEN accumulator.
  - Divide: restoring shift-subtract.
  - The counter decrements each cycle. When the counter reaches 1, go to DONE.
- On the transition into DONE, register the result:
  - Apply two's-complement negation if the negate flag is set.
  - MUL returns the low XLEN bits of the product.
  - MULH, MULHSU and MULHU return the high XLEN bits.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- DONE: `done_o`=1, then return to IDLE. `start_i` is ignored in DONE.
- `busy_o` = (IDLE & `start_i` & ~`flush_i`) | CALC. This is combinational so the stall takes effect in the same cycle the op enters EX.
- `busy_o` is 0 in DONE, so the pipeline advances and captures `result_o`.
- `flush_i` has priority in every state:
  - The next state is IDLE.
  - `done_o` is not asserted and `result_o` is not updated.
  - A `start_i` in the same cycle is dropped.
- Arithmetic widths:
  - Accumulator: 2·XLEN+1 bits; the extra bit covers MULHSU sign extension.
  - Remainder register: XLEN+1 bits.
  - Counter: $clog2(N+1) bits.

## Timing
- Reset (asynchronous, immediate): state IDLE, `done_o`=0, `result_o`=0, counter 0, all internal registers 0.
- `busy_o` follows the combinational `start_i`/`flush_i` equation even while in reset.
- Normal op: start accepted in cycle 0; CALC occupies cycles 1..N; `done_o` high in cycle N+1.
- `busy_o` is high in cycles 0..N and low in cycle N+1.
- Special cases: `done_o` high in cycle 1; `busy_o` high only in cycle 0.
- Back-to-back M ops: the second op presents `start_i` in cycle N+2, the earliest legal cycle. Throughput is one op per N+2 cycles.
- `rst` asserted mid-CALC: the state returns to IDLE immediately. No `done_o` pulse occurs, then or after reset release.
- `result_o` changes only on the edge entering DONE.

## Structure
- Add `FUNCT3_MUL` … `FUNCT3_REMU` to the common opcode header.
- Add a `muldiv_state_t` enum (IDLE/CALC/DONE) to the common pipeline-types header.
- Sub-module `muldiv_step`: combinational logic for one `BITS_PER_CYCLE` iteration, covering both the shift-add and shift-subtract paths. It is instantiated once; CALC uses it each cycle.

## Test plan
XLEN=32, BITS_PER_CYCLE=1 unless stated.
- MUL a=7, b=0xFFFFFFFD → `result_o`=0xFFFFFFEB, `done_o` in cycle 33, `busy_o` high in cycles 0..32.
- MULH, MULHU and MULHSU with a=b=0xFFFFFFFF → 0x00000000, 0xFFFFFFFE and 0xFFFFFFFF respectively.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF; REMU a=100, b=7 → 2.
- DIVU 5/0 → 0xFFFFFFFF and REMU 5/0 → 5, each with `done_o` in cycle 1. DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
- Flush in cycle 10 of a DIVU → `busy_o` low in cycle 11, no `done_o`, `result_o` unchanged; a new MUL started in cycle 11 completes correctly.
- BITS_PER_CYCLE=4, XLEN=64: DIVU 2^63/3 → 0x2AAAAAAAAAAAAAAA with `done_o` in cycle 17. Then `rst` pulsed mid-CALC on a second op → all outputs 0 at once, and no `done_o` after release.

Source files
------------

// File: rtl/muldiv_unit_pkg.sv
// Shared definitions for the M-extension multiply/divide unit:
// funct3 encodings, the FSM state type and operand-sign decode helpers.
package muldiv_unit_pkg;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_DONE = 2'd2
    } muldiv_state_t;

    function automatic logic op_a_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_MULHSU) ||
               (f == FUNCT3_DIV)  || (f == FUNCT3_REM);
    endfunction

    function automatic logic op_b_signed(input logic [2:0] f);
        return (f == FUNCT3_MULH) || (f == FUNCT3_DIV) || (f == FUNCT3_REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Execute-stage handshake between the pipeline and the multiply/divide unit.
// The pipeline side is the master; the unit is the slave.
interface muldiv_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [2:0]      funct3_i;
    logic [XLEN-1:0] operand_a_i;
    logic [XLEN-1:0] operand_b_i;
    logic            flush_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] result_o;

    modport master (
        output start_i, funct3_i, operand_a_i, operand_b_i, flush_i,
        input  busy_o, done_o, result_o
    );

    modport slave (
        input  start_i, funct3_i, operand_a_i, operand_b_i, flush_i,
        output busy_o, done_o, result_o
    );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the iterative multiply/divide datapath: BITS_PER_CYCLE
// MSB-first shift-add (multiply) or restoring shift-subtract (divide) steps.
module muldiv_step #(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic              is_div_i,
    input  logic [XLEN-1:0]   opa_i,
    input  logic [XLEN-1:0]   opb_i,
    input  logic [2*XLEN:0]   acc_i,
    input  logic [XLEN:0]     rem_i,
    output logic [XLEN-1:0]   opa_o,
    output logic [2*XLEN:0]   acc_o,
    output logic [XLEN:0]     rem_o
);

    logic [XLEN-1:0] opa_w;
    logic [2*XLEN:0] acc_w;
    logic [XLEN:0]   rem_w;

    // opa doubles as the multiplier shift register and the dividend/quotient register.
    always_comb begin
        opa_w = opa_i;
        acc_w = acc_i;
        rem_w = rem_i;
        for (int i = 0; i < BITS_PER_CYCLE; i++) begin
            if (is_div_i) begin
                rem_w = {rem_w[XLEN-1:0], opa_w[XLEN-1]};
                opa_w = {opa_w[XLEN-2:0], 1'b0};
                if (rem_w >= {1'b0, opb_i}) begin
                    rem_w    = rem_w - {1'b0, opb_i};
                    opa_w[0] = 1'b1;
                end
            end else begin
                acc_w = {acc_w[2*XLEN-1:0], 1'b0} +
                        (opa_w[XLEN-1] ? {{(XLEN+1){1'b0}}, opb_i} : {(2*XLEN+1){1'b0}});
                opa_w = {opa_w[XLEN-2:0], 1'b0};
            end
        end
        opa_o = opa_w;
        acc_o = acc_w;
        rem_o = rem_w;
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RISC-V M-extension multiply/divide unit. Works on operand
// magnitudes and applies the sign fix-up when the result is registered.
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN           = 32,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    muldiv_unit_if.slave bus
);

    localparam int N  = XLEN / BITS_PER_CYCLE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0]   CNT_LOAD = CW'(N);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    muldiv_state_t   state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            neg_q, neg_d;
    logic [XLEN-1:0] opa_q, opa_d;
    logic [XLEN-1:0] opb_q, opb_d;
    logic [2*XLEN:0] acc_q, acc_d;
    logic [XLEN:0]   rem_q, rem_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            done_q, done_d;

    logic            is_rem_in, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;

    logic [XLEN-1:0]   opa_nxt;
    logic [2*XLEN:0]   acc_nxt;
    logic [XLEN:0]     rem_nxt;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, calc_result;
    logic              unused_msbs;

    assign is_rem_in = bus.funct3_i[2] & bus.funct3_i[1];
    assign a_neg     = op_a_signed(bus.funct3_i) & bus.operand_a_i[XLEN-1];
    assign b_neg     = op_b_signed(bus.funct3_i) & bus.operand_b_i[XLEN-1];
    assign a_mag     = a_neg ? -bus.operand_a_i : bus.operand_a_i;
    assign b_mag     = b_neg ? -bus.operand_b_i : bus.operand_b_i;
    assign div_zero  = bus.funct3_i[2] & (bus.operand_b_i == '0);
    assign div_ovf   = bus.funct3_i[2] & ~bus.funct3_i[0] &
                       (bus.operand_a_i == MOST_NEG) & (bus.operand_b_i == '1);

    muldiv_step #(
        .XLEN           (XLEN),
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_step (
        .is_div_i (funct3_q[2]),
        .opa_i    (opa_q),
        .opb_i    (opb_q),
        .acc_i    (acc_q),
        .rem_i    (rem_q),
        .opa_o    (opa_nxt),
        .acc_o    (acc_nxt),
        .rem_o    (rem_nxt)
    );

    // Magnitudes never reach the top bits of acc/rem once the final step is done.
    assign unused_msbs = acc_nxt[2*XLEN] ^ rem_nxt[XLEN];

    assign prod_fix = neg_q ? -acc_nxt[2*XLEN-1:0] : acc_nxt[2*XLEN-1:0];
    assign quo_fix  = neg_q ? -opa_nxt : opa_nxt;
    assign rem_fix  = neg_q ? -rem_nxt[XLEN-1:0] : rem_nxt[XLEN-1:0];

    always_comb begin
        case (funct3_q)
            FUNCT3_MUL:                               calc_result = prod_fix[XLEN-1:0];
            FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU: calc_result = prod_fix[2*XLEN-1:XLEN];
            FUNCT3_DIV, FUNCT3_DIVU:                  calc_result = quo_fix;
            FUNCT3_REM, FUNCT3_REMU:                  calc_result = rem_fix;
            default:                                  calc_result = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        neg_d    = neg_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        result_d = result_q;
        done_d   = 1'b0;
        if (bus.flush_i) begin
            state_d = MD_IDLE;
        end else begin
            case (state_q)
                MD_IDLE: begin
                    if (bus.start_i) begin
                        funct3_d = bus.funct3_i;
                        neg_d    = is_rem_in ? a_neg : (a_neg ^ b_neg);
                        opa_d    = a_mag;
                        opb_d    = b_mag;
                        acc_d    = '0;
                        rem_d    = '0;
                        if (div_zero) begin
                            state_d  = MD_DONE;
                            done_d   = 1'b1;
                            result_d = is_rem_in ? bus.operand_a_i : '1;
                            cnt_d    = '0;
                        end else if (div_ovf) begin
                            state_d  = MD_DONE;
                            done_d   = 1'b1;
                            result_d = is_rem_in ? '0 : bus.operand_a_i;
                            cnt_d    = '0;
                        end else begin
                            state_d = MD_CALC;
                            cnt_d   = CNT_LOAD;
                        end
                    end
                end
                MD_CALC: begin
                    opa_d = opa_nxt;
                    acc_d = acc_nxt;
                    rem_d = rem_nxt;
                    cnt_d = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d  = MD_DONE;
                        done_d   = 1'b1;
                        result_d = calc_result;
                    end
                end
                MD_DONE: state_d = MD_IDLE;
                default: state_d = MD_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MD_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_q    <= 1'b0;
            opa_q    <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            neg_q    <= neg_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // Combinational so the stall lands in the same cycle the op enters EX.
    assign bus.busy_o   = ((state_q == MD_IDLE) & bus.start_i & ~bus.flush_i) |
                          (state_q == MD_CALC);
    assign bus.done_o   = done_q;
    assign bus.result_o = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: a 32-bit radix-2 instance and a
// 64-bit radix-16 instance, checked against hand-computed results.
module tb_muldiv_unit;
    import muldiv_unit_pkg::*;

    logic clk = 1'b0;
    logic rst32;
    logic rst64;
    int   tests = 0;
    int   fails = 0;
    int   done_hits;

    muldiv_unit_if #(.XLEN(32)) if32 ();
    muldiv_unit_if #(.XLEN(64)) if64 ();

    muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u32 (.clk(clk), .rst(rst32), .bus(if32));
    muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) u64 (.clk(clk), .rst(rst64), .bus(if64));

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic st, input logic [2:0] f,
                         input logic [63:0] a, input logic [63:0] b, input logic fl);
        if (s) begin
            if64.start_i = st; if64.funct3_i = f; if64.flush_i = fl;
            if64.operand_a_i = a; if64.operand_b_i = b;
        end else begin
            if32.start_i = st; if32.funct3_i = f; if32.flush_i = fl;
            if32.operand_a_i = a[31:0]; if32.operand_b_i = b[31:0];
        end
    endtask

    function automatic logic dn(input bit s);
        return s ? if64.done_o : if32.done_o;
    endfunction

    function automatic logic bsy(input bit s);
        return s ? if64.busy_o : if32.busy_o;
    endfunction

    function automatic logic [63:0] res(input bit s);
        return s ? if64.result_o : {32'h0, if32.result_o};
    endfunction

    // Start in cycle 0, then follow the op until done_o; checks done cycle,
    // number of busy cycles before done, busy low in the done cycle, and result.
    task automatic run_op(input string tag, input bit s, input bit no_wait, input logic [2:0] f,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] exp_res, input int exp_done);
        int c;
        int busy_cnt;
        bit seen;
        if (!no_wait) begin
            @(posedge clk); #1;
            check({tag, "/idle_done_low"}, {63'b0, dn(s)}, 64'd0);
        end
        drive(s, 1'b1, f, a, b, 1'b0);
        #1;
        busy_cnt = bsy(s) ? 1 : 0;
        @(posedge clk); #1;
        drive(s, 1'b0, f, a, b, 1'b0);
        #1;
        c = 1;
        seen = 0;
        while (!seen && c < 100) begin
            if (dn(s)) begin
                seen = 1;
            end else begin
                if (bsy(s)) busy_cnt++;
                @(posedge clk); #2;
                c++;
            end
        end
        check({tag, "/done_cycle"}, 64'(c), 64'(exp_done));
        check({tag, "/busy_cycles"}, 64'(busy_cnt), 64'(exp_done));
        check({tag, "/busy_in_done"}, {63'b0, bsy(s)}, 64'd0);
        check({tag, "/result"}, res(s), exp_res);
    endtask

    initial begin
        rst32 = 1'b1;
        rst64 = 1'b1;
        drive(0, 1'b0, FUNCT3_MUL, 64'd0, 64'd0, 1'b0);
        drive(1, 1'b0, FUNCT3_MUL, 64'd0, 64'd0, 1'b0);
        #2;
        check("rst32_done", {63'b0, if32.done_o}, 64'd0);
        check("rst32_result", res(0), 64'd0);
        check("rst32_busy", {63'b0, if32.busy_o}, 64'd0);
        check("rst64_result", res(1), 64'd0);
        drive(0, 1'b1, FUNCT3_MUL, 64'd7, 64'd3, 1'b0);
        #1;
        check("rst_busy_follows_start", {63'b0, if32.busy_o}, 64'd1);
        drive(0, 1'b1, FUNCT3_MUL, 64'd7, 64'd3, 1'b1);
        #1;
        check("rst_busy_flush_masks", {63'b0, if32.busy_o}, 64'd0);
        drive(0, 1'b0, FUNCT3_MUL, 64'd0, 64'd0, 1'b0);
        @(posedge clk); @(posedge clk); #1;
        rst32 = 1'b0;
        rst64 = 1'b0;

        run_op("mul_7xm3",   0, 0, FUNCT3_MUL,    64'h7,        64'hFFFFFFFD, 64'hFFFFFFEB, 33);
        run_op("mul_m3xm5",  0, 0, FUNCT3_MUL,    64'hFFFFFFFD, 64'hFFFFFFFB, 64'h0000000F, 33);
        run_op("mulh_m1",    0, 0, FUNCT3_MULH,   64'hFFFFFFFF, 64'hFFFFFFFF, 64'h00000000, 33);
        run_op("mulhu_max",  0, 0, FUNCT3_MULHU,  64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFE, 33);
        run_op("mulhsu_m1",  0, 0, FUNCT3_MULHSU, 64'hFFFFFFFF, 64'hFFFFFFFF, 64'hFFFFFFFF, 33);
        run_op("div_m7_2",   0, 0, FUNCT3_DIV,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFD, 33);
        run_op("rem_m7_2",   0, 0, FUNCT3_REM,    64'hFFFFFFF9, 64'h2,        64'hFFFFFFFF, 33);
        run_op("remu_100_7", 0, 0, FUNCT3_REMU,   64'd100,      64'd7,        64'd2,        33);
        run_op("divu_5_0",   0, 0, FUNCT3_DIVU,   64'd5,        64'd0,        64'hFFFFFFFF, 1);
        run_op("remu_5_0",   0, 0, FUNCT3_REMU,   64'd5,        64'd0,        64'd5,        1);
        run_op("div_ovf",    0, 0, FUNCT3_DIV,    64'h80000000, 64'hFFFFFFFF, 64'h80000000, 1);
        run_op("rem_ovf",    0, 0, FUNCT3_REM,    64'h80000000, 64'hFFFFFFFF, 64'h00000000, 1);
        run_op("div_m7_0",   0, 0, FUNCT3_DIV,    64'hFFFFFFF9, 64'd0,        64'hFFFFFFFF, 1);
        run_op("rem_m7_0",   0, 0, FUNCT3_REM,    64'hFFFFFFF9, 64'd0,        64'hFFFFFFF9, 1);

        // Flush a DIVU in cycle 10, then start a MUL in cycle 11.
        @(posedge clk); #1;
        drive(0, 1'b1, FUNCT3_DIVU, 64'd1000, 64'd3, 1'b0);
        done_hits = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            drive(0, 1'b0, FUNCT3_DIVU, 64'd1000, 64'd3, c == 10);
            #1;
            if (if32.done_o) done_hits++;
        end
        @(posedge clk); #1;
        drive(0, 1'b0, FUNCT3_MUL, 64'd0, 64'd0, 1'b0);
        #1;
        if (if32.done_o) done_hits++;
        check("flush/busy_c11", {63'b0, if32.busy_o}, 64'd0);
        check("flush/no_done", 64'(done_hits), 64'd0);
        check("flush/result_kept", res(0), 64'hFFFFFFF9);
        run_op("mul_after_flush", 0, 1, FUNCT3_MUL, 64'h00012345, 64'h10, 64'h00123450, 33);

        // start together with flush in IDLE is dropped.
        @(posedge clk); #1;
        drive(0, 1'b1, FUNCT3_MUL, 64'd3, 64'd3, 1'b1);
        #1;
        check("start_flush/busy", {63'b0, if32.busy_o}, 64'd0);
        @(posedge clk); #1;
        drive(0, 1'b0, FUNCT3_MUL, 64'd0, 64'd0, 1'b0);
        #1;
        check("start_flush/not_started", {63'b0, if32.busy_o}, 64'd0);
        done_hits = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #2;
            if (if32.done_o) done_hits++;
        end
        check("start_flush/no_done", 64'(done_hits), 64'd0);
        check("start_flush/result_kept", res(0), 64'h00123450);

        run_op("divu64_r16", 1, 0, FUNCT3_DIVU, 64'h8000000000000000, 64'd3,
               64'h2AAAAAAAAAAAAAAA, 17);

        // Reset pulsed in the middle of a 64-bit CALC.
        @(posedge clk); #1;
        drive(1, 1'b1, FUNCT3_DIVU, 64'h8000000000000000, 64'd3, 1'b0);
        @(posedge clk); #1;
        drive(1, 1'b0, FUNCT3_DIVU, 64'h8000000000000000, 64'd3, 1'b0);
        #1;
        check("rst_mid/busy_before", {63'b0, if64.busy_o}, 64'd1);
        for (int c = 2; c <= 5; c++) begin
            @(posedge clk); #1;
        end
        rst64 = 1'b1;
        #1;
        check("rst_mid/busy", {63'b0, if64.busy_o}, 64'd0);
        check("rst_mid/done", {63'b0, if64.done_o}, 64'd0);
        check("rst_mid/result", res(1), 64'd0);
        @(posedge clk); #1;
        rst64 = 1'b0;
        done_hits = 0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk); #2;
            if (if64.done_o) done_hits++;
        end
        check("rst_mid/no_done_after", 64'(done_hits), 64'd0);
        check("rst_mid/result_after", res(1), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
